// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM encoding and instruction/IROM geometry
// used by the fetch unit, the IR and the IROM.
package proc_pkg;

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_LOAD} fetch_state_t;

  localparam int INSTR_W     = 16;
  localparam int IROM_ADDR_W = 7;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the synchronous IROM, waits out its
// latency and pulses the IR load, redirecting the PC on jumps.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W  = IROM_ADDR_W,
  parameter int DATA_W  = INSTR_W,
  parameter int ROM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Fetch_req,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] Jump_addr,
  input  logic [DATA_W-1:0] Rom_data,
  output logic [ADDR_W-1:0] Rom_addr,
  output logic              Ir_load,
  output logic [DATA_W-1:0] Ir_data,
  output logic              Fetch_done,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC
);

  localparam int CNT_W = (ROM_LAT > 1) ? 2 : 1;

  fetch_state_t      state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_vld;
  logic              last_wait;

  assign last_wait = (wait_cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      F_IDLE:  if (Fetch_req) state_nxt = F_WAIT;
      F_WAIT:  if (last_wait) state_nxt = F_LOAD;
      F_LOAD:  state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  // PC is frozen from accept through the LOAD edge so the ROM word stays
  // stable while the IR captures it; jumps seen while busy are deferred.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= F_IDLE;
      wait_cnt   <= '0;
      pc_q       <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      Ir_load    <= 1'b0;
      Fetch_done <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      Ir_load    <= (state_nxt == F_LOAD);
      Fetch_done <= (state == F_LOAD);
      Busy       <= (state_nxt != F_IDLE);
      case (state)
        F_IDLE: begin
          if (Fetch_req) wait_cnt <= CNT_W'(ROM_LAT);
          if (Jump)      pc_q     <= Jump_addr;
        end
        F_WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (Jump) begin
            pend_vld  <= 1'b1;
            pend_addr <= Jump_addr;
          end
        end
        F_LOAD: begin
          // A jump arriving in the LOAD cycle is newer than any pending one.
          if (Jump)          pc_q <= Jump_addr;
          else if (pend_vld) pc_q <= pend_addr;
          else               pc_q <= pc_q + ADDR_W'(1);
          pend_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Rom_addr = pc_q;
  assign PC       = pc_q;
  assign Ir_data  = Rom_data;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: two instances (ROM latency 1 and 3), each
// with a behavioural IROM and IR, checked against a transaction-level PC model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freq  [2];
  logic        jmp   [2];
  logic [6:0]  jaddr [2];
  logic [15:0] romd  [2];
  logic [6:0]  roma  [2];
  logic        irl   [2];
  logic [15:0] ird   [2];
  logic        fdone [2];
  logic        busy  [2];
  logic [6:0]  pcw   [2];
  logic [15:0] irq   [2];

  logic [15:0] rom_mem [128];
  logic [6:0]  mpc [2];
  logic        prev_irl [2];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [15:0] p0, p1, p2;

    instr_fetch #(.ADDR_W(7), .DATA_W(16), .ROM_LAT(LAT)) u_dut (
      .Clock(clk), .Reset_n(rst_n), .Fetch_req(freq[g]), .Jump(jmp[g]),
      .Jump_addr(jaddr[g]), .Rom_data(romd[g]), .Rom_addr(roma[g]),
      .Ir_load(irl[g]), .Ir_data(ird[g]), .Fetch_done(fdone[g]),
      .Busy(busy[g]), .PC(pcw[g])
    );

    always @(posedge clk) begin
      p0 <= rom_mem[roma[g]];
      p1 <= p0;
      p2 <= p1;
    end
    assign romd[g] = (LAT == 1) ? p0 : (LAT == 2) ? p1 : p2;

    always @(posedge clk or negedge rst_n)
      if (!rst_n) irq[g] <= 16'h0;
      else if (irl[g]) irq[g] <= ird[g];
  end

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // Ir_load must be an isolated pulse and never coincide with Fetch_done.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (irl[g] === 1'b1 && (fdone[g] === 1'b1 || prev_irl[g] === 1'b1)) begin
        failures++;
        $display("FAIL pulse_rules dut%0d ir_load=%b fetch_done=%b prev_ir_load=%b want isolated pulse",
                 g, irl[g], fdone[g], prev_irl[g]);
      end
      prev_irl[g] = irl[g];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      freq[g] = 1'b0; jmp[g] = 1'b0; jaddr[g] = 7'h0; mpc[g] = 7'h0;
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  // One fetch transaction; expectations come from the model PC and ROM contents.
  task automatic run_fetch(input int g, input bit ji, input logic [6:0] ja,
                           input bit jbz, input int jbc, input logic [6:0] jb,
                           input bit hold2, input string nm);
    int L = lat(g);
    int cnt = 0;
    bit seen = 0;
    logic [6:0] ea, np;
    ea = ji ? ja : mpc[g];
    np = jbz ? jb : 7'(ea + 7'd1);
    freq[g] = 1'b1; jmp[g] = ji; jaddr[g] = ja;
    while (!seen && cnt < 12) begin
      tick; cnt++;
      if (cnt == 1) begin
        checks++;
        if (busy[g] !== 1'b1 || pcw[g] !== ea) begin
          failures++;
          $display("FAIL %s_accept dut%0d busy=%b pc=%h want busy=1 pc=%h", nm, g, busy[g], pcw[g], ea);
        end
      end
      freq[g] = hold2 && cnt == 1;
      jmp[g]  = jbz && cnt == jbc;
      if (jbz && cnt == jbc) jaddr[g] = jb;
      if (irl[g] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cnt != L + 1) begin
      failures++;
      $display("FAIL %s_latency dut%0d ir_load_seen=%0d at_cycle=%0d want cycle %0d", nm, g, seen, cnt, L + 1);
    end
    checks++;
    if (ird[g] !== rom_mem[ea] || roma[g] !== ea || pcw[g] !== ea) begin
      failures++;
      $display("FAIL %s_load dut%0d ir_data=%h rom_addr=%h pc=%h want data=%h addr=%h",
               nm, g, ird[g], roma[g], pcw[g], rom_mem[ea], ea);
    end
    tick; cnt++;
    freq[g] = 1'b0; jmp[g] = 1'b0;
    checks++;
    if (fdone[g] !== 1'b1 || irl[g] !== 1'b0 || busy[g] !== 1'b0) begin
      failures++;
      $display("FAIL %s_done dut%0d fetch_done=%b ir_load=%b busy=%b want 1 0 0", nm, g, fdone[g], irl[g], busy[g]);
    end
    checks++;
    if (pcw[g] !== np || irq[g] !== rom_mem[ea]) begin
      failures++;
      $display("FAIL %s_result dut%0d pc=%h ir=%h want pc=%h ir=%h", nm, g, pcw[g], irq[g], np, rom_mem[ea]);
    end
    mpc[g] = np;
  endtask

  task automatic idle_jump(input int g, input logic [6:0] a);
    jmp[g] = 1'b1; jaddr[g] = a;
    tick;
    jmp[g] = 1'b0;
    mpc[g] = a;
    checks++;
    if (pcw[g] !== a || roma[g] !== a) begin
      failures++;
      $display("FAIL idle_jump dut%0d pc=%h rom_addr=%h want %h", g, pcw[g], roma[g], a);
    end
  endtask

  task automatic test_reset;
    int pulses = 0;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pcw[g] !== 7'h0 || roma[g] !== 7'h0 || busy[g] !== 1'b0 || irl[g] !== 1'b0 || fdone[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d pc=%h addr=%h busy=%b ld=%b done=%b want all zero",
                 g, pcw[g], roma[g], busy[g], irl[g], fdone[g]);
      end
    end
    do_reset;
    run_fetch(1, 0, 7'h0, 0, 1, 7'h0, 0, "pre_reset");
    freq[1] = 1'b1;
    tick;
    freq[1] = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pcw[1] !== 7'h0 || roma[1] !== 7'h0 || busy[1] !== 1'b0 || fdone[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_wait pc=%h addr=%h busy=%b done=%b want 0 0 0 0", pcw[1], roma[1], busy[1], fdone[1]);
    end
    for (int k = 0; k < 8; k++) begin
      tick;
      if (k == 1) rst_n = 1'b1;
      if (irl[1] === 1'b1 || fdone[1] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_abort pulses=%0d want 0", pulses);
    end
    mpc[0] = 7'h0; mpc[1] = 7'h0;
  endtask

  task automatic test_single;
    do_reset;
    run_fetch(0, 0, 7'h0, 0, 1, 7'h0, 0, "single");
  endtask

  task automatic test_back_to_back;
    logic [6:0] addrs[$];
    int when[$];
    do_reset;
    freq[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick;
      if (k == 12) freq[0] = 1'b0;
      if (irl[0] === 1'b1) begin
        addrs.push_back(roma[0]);
        when.push_back(k);
        checks++;
        if (ird[0] !== rom_mem[roma[0]]) begin
          failures++;
          $display("FAIL b2b_data ir_data=%h want %h", ird[0], rom_mem[roma[0]]);
        end
      end
    end
    checks++;
    if (addrs.size() != 4) begin
      failures++;
      $display("FAIL b2b_count pulses=%0d want 4", addrs.size());
    end
    for (int i = 0; i < addrs.size() && i < 4; i++) begin
      checks++;
      if (addrs[i] !== 7'(i) || (i > 0 && when[i] - when[i-1] != 3)) begin
        failures++;
        $display("FAIL b2b_pulse%0d addr=%h gap=%0d want addr=%h gap=3",
                 i, addrs[i], (i > 0) ? when[i] - when[i-1] : 3, 7'(i));
      end
    end
    checks++;
    if (pcw[0] !== 7'h4) begin
      failures++;
      $display("FAIL b2b_pc pc=%h want 04", pcw[0]);
    end
    mpc[0] = 7'h4;
  endtask

  task automatic test_jump_fetch_idle;
    do_reset;
    run_fetch(0, 1, 7'h40, 0, 1, 7'h0, 0, "jump_idle");
  endtask

  task automatic test_jump_busy;
    do_reset;
    idle_jump(0, 7'h05);
    run_fetch(0, 0, 7'h0, 1, 1, 7'h10, 0, "jump_busy");
    run_fetch(0, 0, 7'h0, 0, 1, 7'h0, 0, "after_jump");
    run_fetch(1, 0, 7'h0, 1, 4, 7'h22, 0, "jump_load");
  endtask

  task automatic test_wrap;
    do_reset;
    idle_jump(1, 7'h7F);
    run_fetch(1, 0, 7'h0, 0, 1, 7'h0, 0, "wrap");
    run_fetch(0, 1, 7'h7F, 0, 1, 7'h0, 0, "wrap_lat1");
  endtask

  task automatic test_random;
    do_reset;
    for (int g = 0; g < 2; g++) begin
      for (int it = 0; it < 25; it++) begin
        int gap = $urandom_range(0, 2);
        for (int k = 0; k < gap; k++) begin
          if ($urandom_range(0, 4) == 0) idle_jump(g, 7'($urandom_range(0, 127)));
          else begin
            tick;
            checks++;
            if (pcw[g] !== mpc[g] || busy[g] !== 1'b0) begin
              failures++;
              $display("FAIL rand_idle dut%0d pc=%h busy=%b want pc=%h busy=0", g, pcw[g], busy[g], mpc[g]);
            end
          end
        end
        run_fetch(g, $urandom_range(0, 3) == 0, 7'($urandom_range(0, 127)),
                  $urandom_range(0, 3) == 0, $urandom_range(1, lat(g) + 1),
                  7'($urandom_range(0, 127)), $urandom_range(0, 1) == 1, "rand");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 16'($urandom);
    rom_mem[0]     = 16'h1234;
    rom_mem[7'h40] = 16'hBEEF;
    for (int g = 0; g < 2; g++) begin
      freq[g] = 1'b0; jmp[g] = 1'b0; jaddr[g] = 7'h0; mpc[g] = 7'h0; prev_irl[g] = 1'b0;
    end
    test_reset;
    test_single;
    test_back_to_back;
    test_jump_fetch_idle;
    test_jump_busy;
    test_wrap;
    test_random;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
